// File: rtl/usb_da_buffer_if.sv
// usb_da_buffer_if: FX3 read-side bus inputs and DAC/status outputs of usb_da_buffer.
// The slave modport is the buffer; the master modport is whoever drives the FX3 side.
interface usb_da_buffer_if #(
  parameter int DQ_W   = 32,
  parameter int DAC_W  = 14,
  parameter int ADDR_W = 10
);
  logic              DATA_DIR;
  logic              SLRD;
  logic [DQ_W-1:0]   DQ;
  logic [DAC_W-1:0]  dac_data;
  logic              dac_valid;
  logic              buf_afull;
  logic [ADDR_W:0]   buf_level;
  logic [15:0]       underflow_cnt;
  logic              overflow;

  modport master (
    output DATA_DIR, SLRD, DQ,
    input  dac_data, dac_valid, buf_afull, buf_level, underflow_cnt, overflow
  );

  modport slave (
    input  DATA_DIR, SLRD, DQ,
    output dac_data, dac_valid, buf_afull, buf_level, underflow_cnt, overflow
  );
endinterface

// File: rtl/usb_da_buffer.sv
// usb_da_buffer: captures FX3 DQ words after SLRD, buffers them, plays half-words to a DAC.
// Optional macro DA_OFFSET_BINARY_EN: emit offset-binary samples and reset dac_data to midscale.
module usb_da_buffer #(
  parameter int DQ_W     = 32,
  parameter int DAC_W    = 14,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 2,
  parameter int PREFILL  = 512,
  parameter int AFULL    = 768,
  parameter int RATE_DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  usb_da_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = $clog2(RATE_DIV);
  localparam logic [ADDR_W:0] LVL_FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_PREFILL = (ADDR_W + 1)'(PREFILL);
  localparam logic [ADDR_W:0] LVL_AFULL   = (ADDR_W + 1)'(AFULL);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(RATE_DIV - 1);

`ifdef DA_OFFSET_BINARY_EN
  localparam logic [DAC_W-1:0] DAC_RST = {1'b1, {(DAC_W - 1){1'b0}}};
`else
  localparam logic [DAC_W-1:0] DAC_RST = '0;
`endif

  typedef enum logic {IDLE, PLAY} state_t;

  // Top DAC_W bits of a half-word; offset-binary builds flip the sign bit.
  function automatic logic [DAC_W-1:0] to_sample(input logic [15:0] h);
    logic [DAC_W-1:0] s;
    s = DAC_W'(h >> (16 - DAC_W));
`ifdef DA_OFFSET_BINARY_EN
    s[DAC_W-1] = ~s[DAC_W-1];
`endif
    return s;
  endfunction

  logic [DQ_W-1:0]   mem [DEPTH];
  state_t            state_q, state_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              half_q, half_d;
  logic [DAC_W-1:0]  dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;
  logic              afull_q, afull_d;
  logic [15:0]       ucnt_q, ucnt_d;
  logic              overflow_q, overflow_d;

  logic              push_req, push_acc, pop, tick, have;
  logic [DQ_W-1:0]   rd_word;
  logic [15:0]       half_w;

  always_comb begin
    rd_pipe_d  = RD_LAT'({rd_pipe_q, ~bus.SLRD & ~bus.DATA_DIR});
    push_req   = rd_pipe_q[RD_LAT-1];
    tick       = (state_q == PLAY) && (div_q == DIV_LAST);
    have       = (level_q != '0);
    pop        = tick && have && half_q;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push_acc   = push_req && ((level_q < LVL_FULL) || pop);
    level_d    = level_q + (ADDR_W + 1)'(push_acc) - (ADDR_W + 1)'(pop);
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push_acc);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    overflow_d = overflow_q | (push_req & ~push_acc);
    afull_d    = (level_q >= LVL_AFULL);
    rd_word    = mem[rd_ptr_q];
    half_w     = half_q ? rd_word[16 +: 16] : rd_word[15:0];

    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    ucnt_d      = ucnt_q;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        half_d = 1'b0;
        if (level_q >= LVL_PREFILL) state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          div_d = '0;
          if (have) begin
            dac_data_d  = to_sample(half_w);
            dac_valid_d = 1'b1;
            half_d      = ~half_q;
          end else begin
            state_d = IDLE;
            half_d  = 1'b0;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_pipe_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      div_q       <= '0;
      half_q      <= 1'b0;
      dac_data_q  <= DAC_RST;
      dac_valid_q <= 1'b0;
      afull_q     <= 1'b0;
      ucnt_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pipe_q   <= rd_pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      div_q       <= div_d;
      half_q      <= half_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      afull_q     <= afull_d;
      ucnt_q      <= ucnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; the cleared level keeps stale words from being played.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc) mem[wr_ptr_q] <= bus.DQ;
  end

  assign bus.dac_data      = dac_data_q;
  assign bus.dac_valid     = dac_valid_q;
  assign bus.buf_afull     = afull_q;
  assign bus.buf_level     = level_q;
  assign bus.underflow_cnt = ucnt_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_usb_da_buffer.sv
// tb_usb_da_buffer: randomized FX3 read traffic against a queue-based model of usb_da_buffer.
// Honors DA_OFFSET_BINARY_EN in the same way as the design.
module tb_usb_da_buffer;
  localparam int DQ_W     = 32;
  localparam int DAC_W    = 14;
  localparam int ADDR_W   = 10;
  localparam int RD_LAT   = 2;
  localparam int PREFILL  = 512;
  localparam int AFULL    = 768;
  localparam int RATE_DIV = 4;
  localparam int DEPTH    = 2 ** ADDR_W;

`ifdef DA_OFFSET_BINARY_EN
  localparam logic [DAC_W-1:0] SIGN_FLIP = 14'h2000;
`else
  localparam logic [DAC_W-1:0] SIGN_FLIP = 14'h0000;
`endif

  logic clk;
  logic rst_n;

  usb_da_buffer_if #(.DQ_W(DQ_W), .DAC_W(DAC_W), .ADDR_W(ADDR_W)) bus ();

  usb_da_buffer #(
    .DQ_W(DQ_W), .DAC_W(DAC_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .PREFILL(PREFILL), .AFULL(AFULL), .RATE_DIV(RATE_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words in a queue, strobes in a delay queue, playback as a phase count.
  logic [DQ_W-1:0]  fifo [$];
  bit               hist [$];
  bit               playing;
  int               phase;
  bit               hi_half;
  logic [DAC_W-1:0] m_data;
  bit               m_valid;
  bit               m_afull;
  int               m_ucnt;
  bit               m_ovf;

  function automatic logic [DAC_W-1:0] sample_of(input logic [15:0] h);
    return h[15 -: DAC_W] ^ SIGN_FLIP;
  endfunction

  task automatic model_reset();
    fifo.delete();
    hist.delete();
    for (int i = 0; i < RD_LAT; i++) hist.push_back(1'b0);
    playing = 0;
    phase   = 0;
    hi_half = 0;
    m_data  = SIGN_FLIP;
    m_valid = 0;
    m_afull = 0;
    m_ucnt  = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge();
    int          lvl;
    bit          strobe_due;
    bit          popped;
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lvl        = fifo.size();
    strobe_due = hist.pop_front();
    hist.push_back(!bus.SLRD && !bus.DATA_DIR);
    popped     = 0;
    m_valid    = 0;
    m_afull    = (lvl >= AFULL);
    if (playing) begin
      if (phase == RATE_DIV - 1) begin
        phase = 0;
        if (lvl > 0) begin
          w       = fifo[0];
          m_data  = hi_half ? sample_of(w[31:16]) : sample_of(w[15:0]);
          m_valid = 1;
          if (hi_half) begin
            void'(fifo.pop_front());
            popped = 1;
          end
          hi_half = !hi_half;
        end else begin
          playing = 0;
          hi_half = 0;
          if (m_ucnt < 16'hFFFF) m_ucnt++;
        end
      end else begin
        phase++;
      end
    end else if (lvl >= PREFILL) begin
      playing = 1;
    end
    if (strobe_due) begin
      if (lvl < DEPTH || popped) fifo.push_back(bus.DQ);
      else m_ovf = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dac_valid", 32'(bus.dac_valid), 32'(m_valid));
    chk("dac_data", 32'(bus.dac_data), 32'(m_data));
    chk("buf_level", 32'(bus.buf_level), 32'(fifo.size()));
    chk("buf_afull", 32'(bus.buf_afull), 32'(m_afull));
    chk("underflow_cnt", 32'(bus.underflow_cnt), 32'(m_ucnt));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  // Random traffic: each segment picks a strobe density in eighths.
  task automatic random_traffic(input int segs);
    int dens;
    for (int s = 0; s < segs; s++) begin
      dens = $urandom_range(0, 8);
      for (int c = 0; c < 400; c++) begin
        bus.SLRD     = ($urandom_range(0, 7) < dens) ? 1'b0 : 1'b1;
        bus.DATA_DIR = ($urandom_range(0, 15) == 0);
        bus.DQ       = $urandom;
        step();
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.SLRD     = 1'b1;
    bus.DATA_DIR = 1'b0;
    bus.DQ       = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    chk("rst_dac_data", 32'(bus.dac_data), 32'(SIGN_FLIP));
    chk("rst_level", 32'(bus.buf_level), 32'd0);
    rst_n = 1'b1;

    // Continuous reads with DQ = cycle index until the buffer saturates and drops words.
    for (int i = 0; i < 1500; i++) begin
      bus.SLRD = 1'b0;
      bus.DQ   = (i < 600) ? 32'(i) : $urandom;
      step();
    end
    chk("full_level", 32'(bus.buf_level), 32'(DEPTH));
    chk("full_overflow", 32'(bus.overflow), 32'd1);
    chk("full_afull", 32'(bus.buf_afull), 32'd1);

    // Stop reading; the buffer drains and then underflows exactly once.
    bus.SLRD = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      bus.DATA_DIR = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("drain_ucnt", 32'(bus.underflow_cnt), 32'd1);
    chk("drain_level", 32'(bus.buf_level), 32'd0);
    bus.DATA_DIR = 1'b0;

    random_traffic(10);

    rst_n = 1'b0;
    step();
    chk("midrst_level", 32'(bus.buf_level), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    chk("midrst_dac_data", 32'(bus.dac_data), 32'(SIGN_FLIP));
    rst_n = 1'b1;

    random_traffic(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
